// File: rtl/pc_stack_pkg.sv
// Shared types for the VeriRISC program counter: command encoding and priority decode.
package pc_stack_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INC  = 3'd1,
        CMD_RET  = 3'd2,
        CMD_CALL = 3'd3,
        CMD_LOAD = 3'd4
    } pc_cmd_e;

    // Strict priority: load > call > ret > enable > hold.
    function automatic pc_cmd_e pc_decode(input logic load, input logic call,
                                          input logic ret, input logic enable);
        if (load)        return CMD_LOAD;
        else if (call)   return CMD_CALL;
        else if (ret)    return CMD_RET;
        else if (enable) return CMD_INC;
        else             return CMD_HOLD;
    endfunction

endpackage

// File: rtl/pc_lifo.sv
// Return-address LIFO; push is ignored when full and pop when empty.
module pc_lifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

    logic [OW-1:0]    occ;
    logic [OW-1:0]    occ_nxt;
    // Sized to the full occupancy index range so occ-1 never indexes out of bounds.
    logic [WIDTH-1:0] mem [0:(1<<OW)-1];

    always_comb begin
        occ_nxt = occ;
        if (push && !full)
            occ_nxt = occ + 1'b1;
        else if (pop && !empty)
            occ_nxt = occ - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            occ   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            occ   <= occ_nxt;
            full  <= (occ_nxt == DEPTH_OCC);
            empty <= (occ_nxt == '0);
        end
    end

    // Contents are deliberately not reset; only occupancy defines validity.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[occ] <= wdata;
    end

    assign rdata = mem[occ - 1'b1];

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with call/return stack. Define PC_STACK_ERR_EN to enable the
// sticky ovf_err/unf_err flags and err_clr; otherwise the flags are tied to 0.
module pc_stack_counter
    import pc_stack_pkg::*;
#(
    parameter int               WIDTH     = 5,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic             enable,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             ovf_err,
    output logic             unf_err
);

    pc_cmd_e          cmd;
    logic [WIDTH-1:0] top;
    logic             do_push;
    logic             do_pop;

    assign cmd     = pc_decode(load, call, ret, enable);
    assign do_push = (cmd == CMD_CALL);
    assign do_pop  = (cmd == CMD_RET);

    pc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (count + 1'b1),
        .rdata (top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= RESET_VAL;
        end else begin
            case (cmd)
                CMD_LOAD: count <= data;
                CMD_CALL: count <= data;
                CMD_RET:  if (!stack_empty) count <= top;
                CMD_INC:  count <= count + 1'b1;
                default:  count <= count;
            endcase
        end
    end

`ifdef PC_STACK_ERR_EN
    // A same-cycle error event takes precedence over err_clr.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (do_push && stack_full)
                ovf_err <= 1'b1;
            else if (err_clr)
                ovf_err <= 1'b0;
            if (do_pop && stack_empty)
                unf_err <= 1'b1;
            else if (err_clr)
                unf_err <= 1'b0;
        end
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_counter.sv
// Randomized and directed bench for pc_stack_counter against a queue-based reference model.
module tb_pc_stack_counter;

`ifdef PC_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_;
    logic [4:0] data;
    logic       load, call, ret, enable, err_clr;
    logic [4:0] count;
    logic       stack_full, stack_empty, ovf_err, unf_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [4:0] m_count;
    logic [4:0] m_stk[$];
    logic       m_ovf, m_unf;
    logic [4:0] exp_q[$];

    pc_stack_counter #(.WIDTH(5), .DEPTH(4), .RESET_VAL(5'd0)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .data        (data),
        .load        (load),
        .call        (call),
        .ret         (ret),
        .enable      (enable),
        .err_clr     (err_clr),
        .count       (count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 5'd0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic l, c, r, e, ec, input logic [4:0] d);
        bit ovf_ev = 0;
        bit unf_ev = 0;
        if (l) begin
            m_count = d;
        end else if (c) begin
            if (m_stk.size() < 4) m_stk.push_back(m_count + 5'd1);
            else ovf_ev = 1;
            m_count = d;
        end else if (r) begin
            if (m_stk.size() > 0) m_count = m_stk.pop_back();
            else unf_ev = 1;
        end else if (e) begin
            m_count = m_count + 5'd1;
        end
        if (ERR_EN) begin
            if (ovf_ev) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
            if (unf_ev) m_unf = 1'b1; else if (ec) m_unf = 1'b0;
        end
        exp_q.push_back(m_count);
    endtask

    task automatic check_all(input string tag);
        logic [4:0] e;
        e = exp_q.pop_front();
        check({tag, "_count"}, count, e);
        check({tag, "_full"},  stack_full,  m_stk.size() == 4);
        check({tag, "_empty"}, stack_empty, m_stk.size() == 0);
        check({tag, "_ovf"},   ovf_err, m_ovf);
        check({tag, "_unf"},   unf_err, m_unf);
    endtask

    // driver: one command per cycle, checked 1 time unit after the edge
    task automatic step(input string tag, input logic l, c, r, e, ec, input logic [4:0] d);
        load = l; call = c; ret = r; enable = e; err_clr = ec; data = d;
        @(posedge clk);
        model_step(l, c, r, e, ec, d);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        model_reset();
        load = 0; call = 0; ret = 0; enable = 0; err_clr = 0; data = '0;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        check("reset_count", count, 5'd0);
        check("reset_empty", stack_empty, 1'b1);
        check("reset_full",  stack_full, 1'b0);
        check("reset_ovf",   ovf_err, 1'b0);
        check("reset_unf",   unf_err, 1'b0);
    endtask

    initial begin
        do_reset();

        // free-running increment with wrap
        for (int i = 0; i < 33; i++) step("inc", 0, 0, 0, 1, 0, 5'd0);
        check("inc_wrap_val", count, 5'd1);

        // load / call / ret
        step("ld20", 1, 0, 0, 0, 0, 5'd20);
        check("plan_ld", count, 5'd20);
        step("call8", 0, 1, 0, 0, 0, 5'd8);
        check("plan_call", count, 5'd8);
        step("ret", 0, 0, 1, 0, 0, 5'd0);
        check("plan_ret", count, 5'd21);

        // overflow sequence from count 0
        step("ld0", 1, 0, 0, 0, 0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            step("call1", 0, 1, 0, 0, 0, 5'd1);
            if (i == 3) check("plan_full4", stack_full, 1'b1);
        end
        check("plan_ovf", ovf_err, ERR_EN);
        check("plan_ovf_cnt", count, 5'd1);
        step("r1", 0, 0, 1, 0, 0, 5'd0); check("plan_r1", count, 5'd2);
        step("r2", 0, 0, 1, 0, 0, 5'd0); check("plan_r2", count, 5'd2);
        step("r3", 0, 0, 1, 0, 0, 5'd0); check("plan_r3", count, 5'd2);
        step("r4", 0, 0, 1, 0, 0, 5'd0); check("plan_r4", count, 5'd1);
        step("clr", 0, 0, 0, 0, 1, 5'd0);

        // underflow and err_clr precedence
        step("ld7", 1, 0, 0, 0, 0, 5'd7);
        step("uret", 0, 0, 1, 0, 0, 5'd0);
        check("plan_unf_cnt", count, 5'd7);
        check("plan_unf", unf_err, ERR_EN);
        step("uclr", 0, 0, 0, 0, 1, 5'd0);
        check("plan_unf_clr", unf_err, 1'b0);
        step("uret2", 0, 0, 1, 0, 0, 5'd0);
        step("uclr_ret", 0, 0, 1, 0, 1, 5'd0);
        check("plan_unf_win", unf_err, ERR_EN);

        // priority
        step("prio_lce", 1, 1, 0, 1, 0, 5'd12);
        check("plan_prio_cnt", count, 5'd12);
        check("plan_prio_stk", stack_empty, 1'b1);
        step("prio_cr", 0, 1, 1, 0, 0, 5'd3);
        check("plan_cr_cnt", count, 5'd3);
        check("plan_cr_stk", stack_empty, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic l, c, r, e, ec;
            l  = ($urandom_range(0, 9) == 0);
            c  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 1) == 0);
            ec = ($urandom_range(0, 7) == 0);
            step("rnd", l, c, r, e, ec, 5'($urandom_range(0, 31)));
        end

        // asynchronous reset mid-cycle with two entries stacked
        step("pre_ld", 1, 0, 0, 0, 0, 5'd9);
        step("pre_c1", 0, 1, 0, 0, 0, 5'd14);
        step("pre_c2", 0, 1, 0, 0, 0, 5'd17);
        step("pre_ovf", 0, 0, 0, 0, 0, 5'd0);
        load = 0; call = 0; ret = 0; enable = 1; err_clr = 0;
        #2;
        rst_ = 1'b0;
        #1;
        check("async_count", count, 5'd0);
        check("async_empty", stack_empty, 1'b1);
        check("async_full",  stack_full, 1'b0);
        check("async_ovf",   ovf_err, 1'b0);
        check("async_unf",   unf_err, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold", count, 5'd0);
        @(negedge clk);
        rst_ = 1'b1;
        step("post_inc", 0, 0, 0, 1, 0, 5'd0);
        check("post_inc_val", count, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
